// File: rtl/uart_note_rx_if.sv
// Serial link bundle between the host keyboard UART line and the note receiver.
// The receiver side takes the line and produces the note code, strobes and busy;
// the host side (or a bench) drives the line and observes the results.
interface uart_note_rx_if;
    logic       RxD;
    logic [7:0] data;
    logic       data_valid;
    logic       frame_err;
    logic       busy;

    modport master (
        output RxD,
        input  data,
        input  data_valid,
        input  frame_err,
        input  busy
    );

    modport slave (
        input  RxD,
        output data,
        output data_valid,
        output frame_err,
        output busy
    );
endinterface

// File: rtl/uart_note_rx.sv
// 8N1 UART receiver for the piano note link.
// 16x oversampling, 3-sample majority vote at ticks 7/8/9 of each bit, start-bit
// glitch rejection, framing-error detection and break handling. The last good
// byte is held on data with a one-cycle data_valid strobe; every output is driven
// from a register.
module uart_note_rx #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16          // sample counter below assumes 16
) (
    input  logic          clk,
    input  logic          reset,
    uart_note_rx_if.slave bus
);

    localparam int DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_t;

    // Majority of three samples.
    function automatic logic f_maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    state_t             r_state;
    state_t             w_state_nxt;

    logic               r_sync1;
    logic               r_sync2;
    logic               w_rxs;

    logic [DIV_W-1:0]   r_div;
    logic [3:0]         r_s;
    logic [2:0]         r_bit;
    logic [1:0]         r_smp;
    logic [7:0]         r_shift;
    logic               r_start_ok;

    logic [7:0]         r_data;
    logic               r_data_valid;
    logic               r_frame_err;
    logic               r_busy;

    logic               w_tick;
    logic               w_dec;
    logic               w_end;
    logic               w_maj;

    logic               w_clear;
    logic               w_load;
    logic               w_ferr;
    logic               w_shift_en;
    logic               w_bit_clr;
    logic               w_bit_inc;
    logic               w_start_ok_set;
    logic               w_busy_nxt;

    assign w_rxs  = r_sync2;

    // A tick event advances r_s; the tick reached is r_s+1, so r_s==8 is tick 9
    // (the decision point) and r_s==14 is tick 15 (last tick of the bit).
    assign w_tick = (r_div == DIV_W'(DIV - 1));
    assign w_dec  = w_tick && (r_s == 4'd8);
    assign w_end  = w_tick && (r_s == 4'd14);

    // r_smp[1] holds tick 7, r_smp[0] tick 8; the live sample is tick 9.
    assign w_maj  = f_maj3(r_smp[1], r_smp[0], w_rxs);

    // Two-flop synchronizer; idles high so reset never looks like a start edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= bus.RxD;
            r_sync2 <= r_sync1;
        end
    end

    // Tick divider and per-bit sample counter; realigned to the start edge.
    always_ff @(posedge clk) begin
        if (reset || w_clear) begin
            r_div <= '0;
            r_s   <= 4'd0;
        end else if (w_tick) begin
            r_div <= '0;
            r_s   <= r_s + 4'd1;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    // Capture the tick-7 and tick-8 samples for the majority vote.
    always_ff @(posedge clk) begin
        if (w_tick && ((r_s == 4'd6) || (r_s == 4'd7))) begin
            r_smp <= {r_smp[0], w_rxs};
        end
    end

    // Data shift register, LSB arrives first so new bits enter at the top.
    always_ff @(posedge clk) begin
        if (w_shift_en) begin
            r_shift <= {w_maj, r_shift[7:1]};
        end
    end

    // Bit index within the data field.
    always_ff @(posedge clk) begin
        if (reset || w_bit_clr) begin
            r_bit <= 3'd0;
        end else if (w_bit_inc) begin
            r_bit <= r_bit + 3'd1;
        end
    end

    // Remembers that the current start bit passed its majority check.
    always_ff @(posedge clk) begin
        if (reset || w_clear) begin
            r_start_ok <= 1'b0;
        end else if (w_start_ok_set) begin
            r_start_ok <= 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state and per-cycle control decode.
    always_comb begin
        w_state_nxt    = r_state;
        w_clear        = 1'b0;
        w_load         = 1'b0;
        w_ferr         = 1'b0;
        w_shift_en     = 1'b0;
        w_bit_clr      = 1'b0;
        w_bit_inc      = 1'b0;
        w_start_ok_set = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (!w_rxs) begin
                    w_state_nxt = ST_START;
                    w_clear     = 1'b1;
                end
            end
            ST_START: begin
                if (w_dec) begin
                    if (w_maj) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_start_ok_set = 1'b1;
                    end
                end else if (w_end && r_start_ok) begin
                    w_state_nxt = ST_DATA;
                    w_bit_clr   = 1'b1;
                end
            end
            ST_DATA: begin
                if (w_dec) begin
                    w_shift_en = 1'b1;
                end
                if (w_end) begin
                    if (r_bit == 3'd7) begin
                        w_state_nxt = ST_STOP;
                    end else begin
                        w_bit_inc = 1'b1;
                    end
                end
            end
            ST_STOP: begin
                // Re-arm at mid-stop so a start bit right after the stop bit is caught.
                if (w_dec) begin
                    if (w_maj) begin
                        w_load      = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_ferr      = 1'b1;
                        w_state_nxt = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                // A held-low line must go high before another start is accepted.
                if (w_rxs) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Busy for the cycle following this one, so the output stays registered.
    always_comb begin
        w_busy_nxt = 1'b0;
        case (w_state_nxt)
            ST_START: w_busy_nxt = (r_state == ST_START) && (r_start_ok || w_start_ok_set);
            ST_DATA:  w_busy_nxt = 1'b1;
            ST_STOP:  w_busy_nxt = 1'b1;
            default:  w_busy_nxt = 1'b0;
        endcase
    end

    // Registered outputs: held note code, one-cycle strobes and busy.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data       <= 8'h00;
            r_data_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_data_valid <= w_load;
            r_frame_err  <= w_ferr;
            r_busy       <= w_busy_nxt;
            if (w_load) begin
                r_data <= r_shift;
            end
        end
    end

    assign bus.data       = r_data;
    assign bus.data_valid = r_data_valid;
    assign bus.frame_err  = r_frame_err;
    assign bus.busy       = r_busy;

endmodule

// File: tb/tb_uart_note_rx.sv
// Directed bench for uart_note_rx at DIV=10 (160 clocks per bit).
`timescale 1ns/1ps
module tb_uart_note_rx;

    localparam int CLK_FREQ = 1_600_000;
    localparam int BAUD     = 10_000;
    localparam int BIT_CLK  = 160;

    logic clk = 1'b0;
    logic reset = 1'b1;

    uart_note_rx_if bus();

    uart_note_rx #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .OVERSAMPLE (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Free-running cycle count and output monitor.
    int       cyc = 0;
    int       n_dv = 0;
    int       n_fe = 0;
    int       n_busy = 0;
    int       viol = 0;
    int       last_dv_cyc = 0;
    logic     prev_dv = 1'b0;
    logic     prev_fe = 1'b0;
    logic [7:0] dv_data [0:63];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        prev_dv <= bus.data_valid;
        prev_fe <= bus.frame_err;
        if (bus.busy) n_busy <= n_busy + 1;
        if (bus.frame_err) n_fe <= n_fe + 1;
        if (bus.data_valid) begin
            if (n_dv < 64) dv_data[n_dv] <= bus.data;
            n_dv        <= n_dv + 1;
            last_dv_cyc <= cyc;
        end
        if ((bus.data_valid && bus.frame_err) ||
            (bus.data_valid && prev_dv) ||
            (bus.frame_err && prev_fe)) begin
            viol <= viol + 1;
        end
    end

    task automatic drive_bit(input logic v, input int n);
        bus.RxD = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v, input int stop_len);
        drive_bit(1'b0, BIT_CLK);
        for (int i = 0; i < 8; i++) drive_bit(b[i], BIT_CLK);
        drive_bit(stop_v, stop_len);
        bus.RxD = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.RxD = 1'b1;
        repeat (5) @(negedge clk);
        checks++; if (bus.data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", bus.data); end
        checks++; if (bus.data_valid !== 1'b0) begin errors++; $display("FAIL reset_dv got %b want 0", bus.data_valid); end
        checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL reset_fe got %b want 0", bus.frame_err); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        reset = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_clean_byte();
        int dv0, fe0, t0;
        dv0 = n_dv; fe0 = n_fe; t0 = cyc;
        send_frame(8'h05, 1'b1, BIT_CLK);
        repeat (40) @(negedge clk);
        checks++; if (n_dv - dv0 !== 1) begin errors++; $display("FAIL clean_dv_count got %0d want 1", n_dv - dv0); end
        checks++; if (bus.data !== 8'h05) begin errors++; $display("FAIL clean_data got %h want 05", bus.data); end
        checks++; if (n_fe - fe0 !== 0) begin errors++; $display("FAIL clean_fe_count got %0d want 0", n_fe - fe0); end
        checks++; if (last_dv_cyc - t0 !== 1533) begin errors++; $display("FAIL clean_latency got %0d want 1533", last_dv_cyc - t0); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL clean_busy_after got %b want 0", bus.busy); end
    endtask

    task automatic test_start_glitch();
        int dv0, fe0, b0;
        dv0 = n_dv; fe0 = n_fe; b0 = n_busy;
        drive_bit(1'b0, 30);
        drive_bit(1'b1, 400);
        checks++; if (n_dv - dv0 !== 0) begin errors++; $display("FAIL glitch_dv_count got %0d want 0", n_dv - dv0); end
        checks++; if (n_fe - fe0 !== 0) begin errors++; $display("FAIL glitch_fe_count got %0d want 0", n_fe - fe0); end
        checks++; if (n_busy - b0 !== 0) begin errors++; $display("FAIL glitch_busy_cycles got %0d want 0", n_busy - b0); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL glitch_busy got %b want 0", bus.busy); end
        checks++; if (bus.data !== 8'h05) begin errors++; $display("FAIL glitch_data got %h want 05", bus.data); end
    endtask

    task automatic test_framing();
        int dv0, fe0;
        dv0 = n_dv; fe0 = n_fe;
        send_frame(8'hA5, 1'b0, 2 * BIT_CLK);
        drive_bit(1'b1, 200);
        checks++; if (n_fe - fe0 !== 1) begin errors++; $display("FAIL frame_fe_count got %0d want 1", n_fe - fe0); end
        checks++; if (n_dv - dv0 !== 0) begin errors++; $display("FAIL frame_dv_count got %0d want 0", n_dv - dv0); end
        checks++; if (bus.data !== 8'h05) begin errors++; $display("FAIL frame_data_kept got %h want 05", bus.data); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL frame_busy got %b want 0", bus.busy); end
        dv0 = n_dv; fe0 = n_fe;
        send_frame(8'h03, 1'b1, BIT_CLK);
        drive_bit(1'b1, 100);
        checks++; if (n_dv - dv0 !== 1) begin errors++; $display("FAIL frame_next_dv got %0d want 1", n_dv - dv0); end
        checks++; if (bus.data !== 8'h03) begin errors++; $display("FAIL frame_next_data got %h want 03", bus.data); end
    endtask

    task automatic test_back_to_back();
        int dv0;
        logic [7:0] d0, d1;
        dv0 = n_dv;
        send_frame(8'h02, 1'b1, BIT_CLK);
        send_frame(8'h0B, 1'b1, BIT_CLK);
        drive_bit(1'b1, 100);
        d0 = dv_data[dv0 % 64];
        d1 = dv_data[(dv0 + 1) % 64];
        checks++; if (n_dv - dv0 !== 2) begin errors++; $display("FAIL b2b_dv_count got %0d want 2", n_dv - dv0); end
        checks++; if (d0 !== 8'h02) begin errors++; $display("FAIL b2b_first got %h want 02", d0); end
        checks++; if (d1 !== 8'h0B) begin errors++; $display("FAIL b2b_second got %h want 0b", d1); end
        checks++; if (bus.data !== 8'h0B) begin errors++; $display("FAIL b2b_data got %h want 0b", bus.data); end
    endtask

    task automatic test_reset_midframe();
        int dv0;
        logic [7:0] b;
        b = 8'h07;
        dv0 = n_dv;
        drive_bit(1'b0, BIT_CLK);
        for (int i = 0; i < 4; i++) drive_bit(b[i], BIT_CLK);
        drive_bit(b[4], BIT_CLK / 2);
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before got %b want 1", bus.busy); end
        // Host abandons the frame while the receiver is reset.
        reset = 1'b1;
        bus.RxD = 1'b1;
        @(negedge clk);
        checks++; if (bus.data !== 8'h00) begin errors++; $display("FAIL rstmid_data got %h want 00", bus.data); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", bus.busy); end
        checks++; if (bus.data_valid !== 1'b0) begin errors++; $display("FAIL rstmid_dv got %b want 0", bus.data_valid); end
        checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL rstmid_fe got %b want 0", bus.frame_err); end
        reset = 1'b0;
        drive_bit(1'b1, 400);
        checks++; if (n_dv - dv0 !== 0) begin errors++; $display("FAIL rstmid_no_strobe got %0d want 0", n_dv - dv0); end
        send_frame(8'h09, 1'b1, BIT_CLK);
        drive_bit(1'b1, 100);
        checks++; if (n_dv - dv0 !== 1) begin errors++; $display("FAIL rstmid_next_dv got %0d want 1", n_dv - dv0); end
        checks++; if (bus.data !== 8'h09) begin errors++; $display("FAIL rstmid_next_data got %h want 09", bus.data); end
    endtask

    task automatic test_majority_vote();
        int dv0;
        logic [7:0] b;
        b = 8'h0A;
        dv0 = n_dv;
        drive_bit(1'b0, BIT_CLK);
        drive_bit(b[0], BIT_CLK);
        // Bit 1 is a one with a 10-clock low spike around its tick-8 sample.
        drive_bit(1'b1, 75);
        drive_bit(1'b0, 10);
        drive_bit(1'b1, 75);
        for (int i = 2; i < 8; i++) drive_bit(b[i], BIT_CLK);
        drive_bit(1'b1, BIT_CLK);
        drive_bit(1'b1, 100);
        checks++; if (n_dv - dv0 !== 1) begin errors++; $display("FAIL vote_dv_count got %0d want 1", n_dv - dv0); end
        checks++; if (bus.data !== 8'h0A) begin errors++; $display("FAIL vote_data got %h want 0a", bus.data); end
    endtask

    task automatic test_pulse_rules();
        checks++; if (viol !== 0) begin errors++; $display("FAIL pulse_rules got %0d violations want 0", viol); end
    endtask

    initial begin
        bus.RxD = 1'b1;
        @(negedge clk);
        test_reset();
        test_clean_byte();
        test_start_glitch();
        test_framing();
        test_back_to_back();
        test_reset_midframe();
        test_majority_vote();
        test_pulse_rules();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
